csr_file: RTL and testbench

CSR_FILE -- requirements
Module: csr_file

---
 rtl/csr_file_if.sv | 38 +++
 rtl/csr_file.sv | 236 +++++++++++++++++++++++
 tb/tb_csr_file.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/csr_file_if.sv
// Bundle of CSR access, commit-stage exception and interrupt-source signals for csr_file.
// master: the pipeline side driving requests; slave: the CSR file.
interface csr_file_if;
  // CSR read/write port (write commits on the same csr_num)
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  // Commit-stage exception / ertn
  logic        wb_ex_valid;
  logic [31:0] wb_ex_pc;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        wb_is_ertn;
  // Level interrupt sources
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  // Status outputs
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        has_int;

  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    output wb_ex_valid, wb_ex_pc, wb_ecode, wb_esubcode, wb_is_ertn,
    output hw_int_in, ipi_int_in,
    input  csr_rvalue, ex_entry, ertn_entry, has_int
  );

  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    input  wb_ex_valid, wb_ex_pc, wb_ecode, wb_esubcode, wb_is_ertn,
    input  hw_int_in, ipi_int_in,
    output csr_rvalue, ex_entry, ertn_entry, has_int
  );
endinterface

// File: rtl/csr_file.sv
// CSR file: CRMD/PRMD/ECFG/ESTAT/ERA/EENTRY/SAVE0-3 with exception/ertn side effects
// and interrupt pending detection. Define CSR_TIMER_EN to add TID/TCFG/TVAL/TICLR.
module csr_file (
  input logic       clk,
  input logic       reset,
  csr_file_if.slave bus
);

  localparam logic [13:0] CsrCrmd   = 14'h000;
  localparam logic [13:0] CsrPrmd   = 14'h001;
  localparam logic [13:0] CsrEcfg   = 14'h004;
  localparam logic [13:0] CsrEstat  = 14'h005;
  localparam logic [13:0] CsrEra    = 14'h006;
  localparam logic [13:0] CsrEentry = 14'h00c;
  localparam logic [13:0] CsrSave0  = 14'h030;
  localparam logic [13:0] CsrSave1  = 14'h031;
  localparam logic [13:0] CsrSave2  = 14'h032;
  localparam logic [13:0] CsrSave3  = 14'h033;
  localparam logic [13:0] CsrTid    = 14'h040;
  localparam logic [13:0] CsrTcfg   = 14'h041;
  localparam logic [13:0] CsrTval   = 14'h042;
  localparam logic [13:0] CsrTiclr  = 14'h044;

  logic [1:0]       crmd_plv_q, crmd_plv_d;
  logic             crmd_ie_q, crmd_ie_d;
  logic             crmd_da_q, crmd_da_d;
  logic [1:0]       prmd_pplv_q, prmd_pplv_d;
  logic             prmd_pie_q, prmd_pie_d;
  logic [12:0]      ecfg_lie_q, ecfg_lie_d;
  logic [1:0]       estat_sw_q, estat_sw_d;
  logic [7:0]       estat_hw_q, estat_hw_d;
  logic             estat_ipi_q, estat_ipi_d;
  logic [5:0]       estat_ecode_q, estat_ecode_d;
  logic [8:0]       estat_esub_q, estat_esub_d;
  logic [31:0]      era_q, era_d;
  logic [25:0]      eentry_q, eentry_d;
  logic [3:0][31:0] save_q, save_d;

  logic        timer_is;  // ESTAT.IS[11]
  logic [12:0] is_vec;
  logic [31:0] rdata;
  logic [31:0] wmerged;
  logic        unused_csr_re;

  assign unused_csr_re = bus.csr_re;

  assign is_vec = {estat_ipi_q, timer_is, 1'b0, estat_hw_q, estat_sw_q};

`ifdef CSR_TIMER_EN
  logic [31:0] tid_q, tid_d;
  logic        tcfg_en_q, tcfg_en_d;
  logic        tcfg_per_q, tcfg_per_d;
  logic [29:0] tcfg_init_q, tcfg_init_d;
  logic [31:0] tval_q, tval_d;
  logic        estat_ti_q, estat_ti_d;
  logic        timer_hit;

  assign timer_is  = estat_ti_q;
  assign timer_hit = tcfg_en_q && (tval_q == 32'd1);

  // Timer next state: a TCFG write reloads the counter, a TICLR write acks, expiry sets IS[11]
  always_comb begin
    tid_d       = tid_q;
    tcfg_en_d   = tcfg_en_q;
    tcfg_per_d  = tcfg_per_q;
    tcfg_init_d = tcfg_init_q;
    tval_d      = tval_q;
    estat_ti_d  = estat_ti_q;
    if (tcfg_en_q && (tval_q != 32'd0)) begin
      tval_d = (timer_hit && tcfg_per_q) ? {tcfg_init_q, 2'b00} : tval_q - 32'd1;
    end
    if (bus.csr_we) begin
      case (bus.csr_num)
        CsrTid: tid_d = wmerged;
        CsrTcfg: begin
          tcfg_en_d   = wmerged[0];
          tcfg_per_d  = wmerged[1];
          tcfg_init_d = wmerged[31:2];
          tval_d      = {wmerged[31:2], 2'b00};
        end
        CsrTiclr: begin
          if (bus.csr_wvalue[0] && bus.csr_wmask[0]) estat_ti_d = 1'b0;
        end
        default: ;
      endcase
    end
    // Expiry beats a simultaneous clear so no tick is lost
    if (timer_hit) estat_ti_d = 1'b1;
  end

  // Timer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tid_q       <= '0;
      tcfg_en_q   <= 1'b0;
      tcfg_per_q  <= 1'b0;
      tcfg_init_q <= '0;
      tval_q      <= '0;
      estat_ti_q  <= 1'b0;
    end else begin
      tid_q       <= tid_d;
      tcfg_en_q   <= tcfg_en_d;
      tcfg_per_q  <= tcfg_per_d;
      tcfg_init_q <= tcfg_init_d;
      tval_q      <= tval_d;
      estat_ti_q  <= estat_ti_d;
    end
  end
`else
  assign timer_is = 1'b0;
`endif

  // Read mux; unimplemented numbers and reserved bits read as zero
  always_comb begin
    rdata = '0;
    case (bus.csr_num)
      CsrCrmd:   rdata = {28'b0, crmd_da_q, crmd_ie_q, crmd_plv_q};
      CsrPrmd:   rdata = {29'b0, prmd_pie_q, prmd_pplv_q};
      CsrEcfg:   rdata = {19'b0, ecfg_lie_q};
      CsrEstat:  rdata = {1'b0, estat_esub_q, estat_ecode_q, 3'b0, is_vec};
      CsrEra:    rdata = era_q;
      CsrEentry: rdata = {eentry_q, 6'b0};
      CsrSave0:  rdata = save_q[0];
      CsrSave1:  rdata = save_q[1];
      CsrSave2:  rdata = save_q[2];
      CsrSave3:  rdata = save_q[3];
`ifdef CSR_TIMER_EN
      CsrTid:    rdata = tid_q;
      CsrTcfg:   rdata = {tcfg_init_q, tcfg_per_q, tcfg_en_q};
      CsrTval:   rdata = tval_q;
      CsrTiclr:  rdata = '0;
`endif
      default:   rdata = '0;
    endcase
  end

  assign bus.csr_rvalue = rdata;
  assign wmerged        = (rdata & ~bus.csr_wmask) | (bus.csr_wvalue & bus.csr_wmask);

  // Next state; later assignments win: csr write < ertn < exception
  always_comb begin
    crmd_plv_d    = crmd_plv_q;
    crmd_ie_d     = crmd_ie_q;
    crmd_da_d     = crmd_da_q;
    prmd_pplv_d   = prmd_pplv_q;
    prmd_pie_d    = prmd_pie_q;
    ecfg_lie_d    = ecfg_lie_q;
    estat_sw_d    = estat_sw_q;
    estat_hw_d    = bus.hw_int_in;
    estat_ipi_d   = bus.ipi_int_in;
    estat_ecode_d = estat_ecode_q;
    estat_esub_d  = estat_esub_q;
    era_d         = era_q;
    eentry_d      = eentry_q;
    save_d        = save_q;
    if (bus.csr_we) begin
      case (bus.csr_num)
        CsrCrmd: begin
          crmd_plv_d = wmerged[1:0];
          crmd_ie_d  = wmerged[2];
          crmd_da_d  = wmerged[3];
        end
        CsrPrmd: begin
          prmd_pplv_d = wmerged[1:0];
          prmd_pie_d  = wmerged[2];
        end
        CsrEcfg:   ecfg_lie_d = {wmerged[12:11], 1'b0, wmerged[9:0]};
        CsrEstat:  estat_sw_d = wmerged[1:0];
        CsrEra:    era_d      = wmerged;
        CsrEentry: eentry_d   = wmerged[31:6];
        CsrSave0:  save_d[0]  = wmerged;
        CsrSave1:  save_d[1]  = wmerged;
        CsrSave2:  save_d[2]  = wmerged;
        CsrSave3:  save_d[3]  = wmerged;
        default: ;
      endcase
    end
    if (bus.wb_is_ertn) begin
      crmd_plv_d = prmd_pplv_q;
      crmd_ie_d  = prmd_pie_q;
    end
    if (bus.wb_ex_valid) begin
      prmd_pplv_d   = crmd_plv_q;
      prmd_pie_d    = crmd_ie_q;
      crmd_plv_d    = 2'b00;
      crmd_ie_d     = 1'b0;
      era_d         = bus.wb_ex_pc;
      estat_ecode_d = bus.wb_ecode;
      estat_esub_d  = bus.wb_esubcode;
    end
  end

  // Control/status registers cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_plv_q    <= 2'b00;
      crmd_ie_q     <= 1'b0;
      crmd_da_q     <= 1'b1;
      prmd_pplv_q   <= 2'b00;
      prmd_pie_q    <= 1'b0;
      ecfg_lie_q    <= '0;
      estat_sw_q    <= '0;
      estat_hw_q    <= '0;
      estat_ipi_q   <= 1'b0;
      estat_ecode_q <= '0;
      estat_esub_q  <= '0;
    end else begin
      crmd_plv_q    <= crmd_plv_d;
      crmd_ie_q     <= crmd_ie_d;
      crmd_da_q     <= crmd_da_d;
      prmd_pplv_q   <= prmd_pplv_d;
      prmd_pie_q    <= prmd_pie_d;
      ecfg_lie_q    <= ecfg_lie_d;
      estat_sw_q    <= estat_sw_d;
      estat_hw_q    <= estat_hw_d;
      estat_ipi_q   <= estat_ipi_d;
      estat_ecode_q <= estat_ecode_d;
      estat_esub_q  <= estat_esub_d;
    end
  end

  // Data registers keep their value through reset but still ignore updates while it is held
  always_ff @(posedge clk) begin
    if (!reset) begin
      era_q    <= era_d;
      eentry_q <= eentry_d;
      save_q   <= save_d;
    end
  end

  assign bus.ex_entry   = {eentry_q, 6'b0};
  assign bus.ertn_entry = era_q;
  // Gated by reset so the output is clean while state is still being initialised
  assign bus.has_int    = ~reset & crmd_ie_q & (|(is_vec & ecfg_lie_q));

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: expected values are queued when stimulus is applied and
// popped when the corresponding DUT output is sampled on the falling edge.
module tb_csr_file;

  logic clk;
  logic reset;
  csr_file_if bus ();

  csr_file dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_q.push_back(val);
    tag_q.push_back(tag);
  endtask

  task automatic compare(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic chk_csr(input logic [13:0] num, input logic [31:0] val, input string tag);
    push_exp(tag, val);
    bus.csr_re  = 1'b1;
    bus.csr_num = num;
    @(negedge clk);
    compare(bus.csr_rvalue);
    bus.csr_re = 1'b0;
  endtask

  task automatic chk_int(input logic val, input string tag);
    push_exp(tag, {31'b0, val});
    @(negedge clk);
    compare({31'b0, bus.has_int});
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] val, input logic [31:0] mask);
    bus.csr_we     = 1'b1;
    bus.csr_num    = num;
    bus.csr_wvalue = val;
    bus.csr_wmask  = mask;
    @(posedge clk);
    #1;
    bus.csr_we    = 1'b0;
    bus.csr_wmask = '0;
  endtask

  task automatic exc(input logic [31:0] pc, input logic [5:0] ecode);
    bus.wb_ex_valid = 1'b1;
    bus.wb_ex_pc    = pc;
    bus.wb_ecode    = ecode;
    bus.wb_esubcode = '0;
    @(posedge clk);
    #1;
    bus.wb_ex_valid = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.csr_re      = 1'b0;
    bus.csr_num     = '0;
    bus.csr_we      = 1'b0;
    bus.csr_wmask   = '0;
    bus.csr_wvalue  = '0;
    bus.wb_ex_valid = 1'b0;
    bus.wb_ex_pc    = '0;
    bus.wb_ecode    = '0;
    bus.wb_esubcode = '0;
    bus.wb_is_ertn  = 1'b0;
    bus.hw_int_in   = '0;
    bus.ipi_int_in  = 1'b0;

    // Reset held for two cycles
    chk_int(1'b0, "has_int_in_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_csr(14'h000, 32'h0000_0008, "reset_crmd");
    chk_csr(14'h005, 32'h0000_0000, "reset_estat");
    chk_csr(14'h001, 32'h0000_0000, "reset_prmd");
    chk_int(1'b0, "reset_has_int");
    chk_csr(14'h002, 32'h0000_0000, "unimpl_read");

    // Masked write and writable-field restrictions
    wr(14'h030, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr(14'h030, 32'h1234_5678, 32'h0000_FFFF);
    chk_csr(14'h030, 32'hFFFF_5678, "save0_masked");
    wr(14'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_csr(14'h004, 32'h0000_1BFF, "ecfg_fields");
    wr(14'h004, 32'h0, 32'hFFFF_FFFF);
    wr(14'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_csr(14'h005, 32'h0000_0003, "estat_sw_only");
    wr(14'h005, 32'h0, 32'h3);
    wr(14'h00c, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_csr(14'h00c, 32'hFFFF_FFC0, "eentry_read");
    push_exp("ex_entry", 32'hFFFF_FFC0);
    @(negedge clk);
    compare(bus.ex_entry);

    // Exception then ertn
    wr(14'h000, 32'h7, 32'h7);
    chk_csr(14'h000, 32'h0000_000F, "crmd_plv3_ie");
    exc(32'h1C00_0100, 6'h0B);
    chk_csr(14'h000, 32'h0000_0008, "ex_crmd");
    chk_csr(14'h001, 32'h0000_0007, "ex_prmd");
    chk_csr(14'h006, 32'h1C00_0100, "ex_era");
    chk_csr(14'h005, 32'h000B_0000, "ex_estat_ecode");
    push_exp("ertn_entry", 32'h1C00_0100);
    @(negedge clk);
    compare(bus.ertn_entry);
    bus.wb_is_ertn = 1'b1;
    @(posedge clk);
    #1;
    bus.wb_is_ertn = 1'b0;
    chk_csr(14'h000, 32'h0000_000F, "ertn_crmd");

    // Exception beats a same-cycle write to IE, but DA from the write still lands
    bus.csr_we     = 1'b1;
    bus.csr_num    = 14'h000;
    bus.csr_wvalue = 32'h4;
    bus.csr_wmask  = 32'hC;
    exc(32'h1C00_0200, 6'h00);
    bus.csr_we    = 1'b0;
    bus.csr_wmask = '0;
    chk_csr(14'h000, 32'h0000_0000, "prio_crmd");
    chk_csr(14'h001, 32'h0000_0007, "prio_prmd");
    chk_csr(14'h006, 32'h1C00_0200, "prio_era");

    // Interrupt pending
    wr(14'h004, 32'h004, 32'hFFFF_FFFF);
    wr(14'h000, 32'h4, 32'h4);
    chk_int(1'b0, "int_none");
    @(posedge clk);
    #1;
    bus.hw_int_in = 8'h01;
    chk_int(1'b0, "int_before_edge");
    chk_int(1'b1, "int_after_edge");
    chk_csr(14'h005, 32'h0000_0004, "estat_hw_is");
    wr(14'h000, 32'h0, 32'h4);
    chk_int(1'b0, "int_ie_off");
    bus.hw_int_in = 8'h00;

    // Reset overrides a simultaneous write, exception and ertn; data CSRs survive
    reset           = 1'b1;
    bus.csr_we      = 1'b1;
    bus.csr_num     = 14'h000;
    bus.csr_wvalue  = 32'h7;
    bus.csr_wmask   = 32'hF;
    bus.wb_ex_valid = 1'b1;
    bus.wb_ex_pc    = 32'hDEAD_0000;
    bus.wb_is_ertn  = 1'b1;
    @(posedge clk);
    #1;
    reset           = 1'b0;
    bus.csr_we      = 1'b0;
    bus.csr_wmask   = '0;
    bus.wb_ex_valid = 1'b0;
    bus.wb_is_ertn  = 1'b0;
    chk_csr(14'h000, 32'h0000_0008, "rst_ovr_crmd");
    chk_csr(14'h001, 32'h0000_0000, "rst_ovr_prmd");
    chk_csr(14'h006, 32'h1C00_0200, "rst_keep_era");
    chk_csr(14'h030, 32'hFFFF_5678, "rst_keep_save0");

`ifdef CSR_TIMER_EN
    // Periodic timer: InitVal=2 -> counts 8..1, fires, reloads 8
    wr(14'h004, 32'h800, 32'hFFFF_FFFF);
    wr(14'h000, 32'h4, 32'h4);
    wr(14'h041, 32'h0000_000B, 32'hFFFF_FFFF);
    bus.csr_num = 14'h042;
    for (int i = 0; i < 8; i++) begin
      push_exp("tval_count", 32'(8 - i));
      push_exp("ti_not_yet", 32'h0);
      @(negedge clk);
      compare(bus.csr_rvalue);
      compare({31'b0, bus.has_int});
    end
    push_exp("tval_reload", 32'h8);
    push_exp("ti_fired", 32'h1);
    @(negedge clk);
    compare(bus.csr_rvalue);
    compare({31'b0, bus.has_int});
    chk_csr(14'h005, 32'h0000_0800, "estat_ti");
    wr(14'h044, 32'h1, 32'h1);
    chk_int(1'b0, "ticlr_int");
    chk_csr(14'h005, 32'h0000_0000, "ticlr_estat");
    wr(14'h041, 32'h0, 32'hFFFF_FFFF);
`else
    // Timer CSRs absent: writes ignored, reads zero, IS[11] never set
    wr(14'h041, 32'h0000_000B, 32'hFFFF_FFFF);
    chk_csr(14'h041, 32'h0, "no_timer_tcfg");
    chk_csr(14'h042, 32'h0, "no_timer_tval");
    repeat (12) @(posedge clk);
    chk_csr(14'h005, 32'h0, "no_timer_estat");
`endif

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
